// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer RAM arbiter: display fetch has priority, writer gets the spare cycles
module fb_arbiter #(
    parameter int unsigned H_PIX   = 320,
    parameter int unsigned V_LINES = 240,
    parameter int unsigned AW      = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    pixel,
    input  logic [7:0]    line,
    output logic [7:0]    video,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [8:0]    wr_x,
    input  logic [7:0]    wr_y,
    input  logic [7:0]    wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [15:0]   clip_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

    state_t        state;
    logic [8:0]    pixel_q;
    logic [7:0]    line_q;
    logic          disp_pend;
    logic          disp_change;
    logic          disp_on;
    logic          wr_on;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // The fetch uses the registered coordinate so the address is stable for the whole slot.
    assign disp_change = (pixel != pixel_q) || (line != line_q);
    assign disp_on     = (32'(pixel_q) < H_PIX) && (32'(line_q) < V_LINES);
    assign wr_on       = (32'(wr_x) < H_PIX) && (32'(wr_y) < V_LINES);
    assign rd_addr     = AW'(line_q) * AW'(H_PIX) + AW'(pixel_q);
    assign wr_addr     = AW'(wr_y) * AW'(H_PIX) + AW'(wr_x);

    // The writer is only offered idle cycles with no display fetch waiting.
    assign wr_ready = (state == S_IDLE) && !disp_pend && !reset;

    // Track timer coordinate changes; a new change wins over the clear so no fetch is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_q   <= 9'd0;
            line_q    <= 8'd0;
            disp_pend <= 1'b1;
        end else begin
            pixel_q <= pixel;
            line_q  <= line;
            if (disp_change) begin
                disp_pend <= 1'b1;
            end else if ((state == S_IDLE) && disp_pend) begin
                disp_pend <= 1'b0;
            end
        end
    end

    // RAM access sequencer: display read, pixel write, or clip of an off-raster write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            video     <= 8'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            clip_cnt  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (disp_pend) begin
                        if (disp_on) begin
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= rd_addr;
                            state    <= S_RD;
                        end else begin
                            video <= 8'd0;
                        end
                    end else if (wr_valid) begin
                        if (wr_on) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= wr_data;
                            state     <= S_WR;
                        end else if (clip_cnt != 16'hFFFF) begin
                            clip_cnt <= clip_cnt + 16'd1;
                        end
                    end
                end
                S_RD: begin
                    mem_en <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    video <= mem_rdata;
                    state <= S_IDLE;
                end
                S_WR: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter
module tb_fb_arbiter;

    localparam int H  = 320;
    localparam int V  = 240;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    pixel;
    logic [7:0]    line;
    logic [7:0]    video;
    logic          wr_valid;
    logic          wr_ready;
    logic [8:0]    wr_x;
    logic [7:0]    wr_y;
    logic [7:0]    wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [15:0]   clip_cnt;

    fb_arbiter #(.H_PIX(H), .V_LINES(V), .AW(AW)) dut (
        .clk(clk), .reset(reset), .pixel(pixel), .line(line), .video(video),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    // Preloaded RAM image: a fixed pattern until an address is written.
    function automatic logic [7:0] pat(input int a);
        if (a == 0)   return 8'h5A;
        if (a == 645) return 8'h33;
        return 8'(a ^ (a >> 8) ^ 32'hA5);
    endfunction

    function automatic bit on_raster(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    function automatic int addr_of(input int x, input int y);
        return y * H + x;
    endfunction

    // Single-port synchronous RAM: read data appears the edge after the read is sampled.
    logic [7:0] ram    [0:(1<<AW)-1];
    bit         ram_wr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
            end
        end
    end

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] cur_video;
    int         exp_clip;
    logic [7:0] exp_mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full 8-clk pixel slot with no writer activity; checks the fetch timeline.
    task automatic show(input int px, input int ln, input logic [7:0] exp_v, input string tag);
        bit on;
        on = on_raster(px, ln);
        pixel = 9'(px);
        line  = 8'(ln);
        step();
        check({tag, ".pend_ready"}, 32'(wr_ready), 0);
        step();
        if (on) begin
            check({tag, ".rd_en"}, 32'(mem_en), 1);
            check({tag, ".rd_we"}, 32'(mem_we), 0);
            check({tag, ".rd_addr"}, 32'(mem_addr), addr_of(px, ln));
            check({tag, ".rd_ready"}, 32'(wr_ready), 0);
            step();
            check({tag, ".rd_done"}, 32'(mem_en), 0);
            check({tag, ".wait_video"}, 32'(video), 32'(cur_video));
            check({tag, ".wait_ready"}, 32'(wr_ready), 0);
            step();
            check({tag, ".video"}, 32'(video), 32'(exp_v));
            check({tag, ".idle_ready"}, 32'(wr_ready), 1);
            repeat (4) step();
        end else begin
            check({tag, ".skip_en"}, 32'(mem_en), 0);
            check({tag, ".skip_video"}, 32'(video), 0);
            check({tag, ".skip_ready"}, 32'(wr_ready), 1);
            repeat (6) step();
        end
        check({tag, ".video_hold"}, 32'(video), 32'(exp_v));
        cur_video = exp_v;
    endtask

    typedef struct {
        int         px;
        int         ln;
        logic [7:0] exp_v;
    } disp_vec_t;

    disp_vec_t tbl [8];

    initial begin
        int px, ln, prev_px, prev_ln, a, e, n;
        bit hs, hs_on, prev_hs_on, changed;
        logic [7:0] exp_v;
        int wq[$];
        int waddrs[$];

        tbl[0] = '{4,   2,   pat(644)};
        tbl[1] = '{5,   2,   8'h33};
        tbl[2] = '{330, 10,  8'h00};
        tbl[3] = '{319, 239, pat(76799)};
        tbl[4] = '{0,   0,   8'h5A};
        tbl[5] = '{100, 240, 8'h00};
        tbl[6] = '{0,   239, pat(76480)};
        tbl[7] = '{319, 0,   pat(319)};

        // Reset state and the forced fetch of pixel (0,0)
        reset = 1'b1; pixel = 9'd0; line = 8'd0;
        wr_valid = 1'b0; wr_x = 9'd0; wr_y = 8'd0; wr_data = 8'd0;
        repeat (3) step();
        check("rst.video", 32'(video), 0);
        check("rst.mem_en", 32'(mem_en), 0);
        check("rst.mem_we", 32'(mem_we), 0);
        check("rst.mem_addr", 32'(mem_addr), 0);
        check("rst.mem_wdata", 32'(mem_wdata), 0);
        check("rst.clip_cnt", 32'(clip_cnt), 0);
        check("rst.wr_ready", 32'(wr_ready), 0);
        reset = 1'b0;
        step();
        check("boot.rd_en", 32'(mem_en), 1);
        check("boot.rd_we", 32'(mem_we), 0);
        check("boot.rd_addr", 32'(mem_addr), 0);
        check("boot.ready", 32'(wr_ready), 0);
        step();
        check("boot.rd_done", 32'(mem_en), 0);
        check("boot.video_e2", 32'(video), 0);
        step();
        check("boot.video", 32'(video), 32'h5A);
        check("boot.idle_ready", 32'(wr_ready), 1);
        cur_video = 8'h5A;
        repeat (2) step();

        // Display fetch table
        for (int i = 0; i < 8; i++) begin
            show(tbl[i].px, tbl[i].ln, tbl[i].exp_v, $sformatf("tbl%0d", i));
        end

        // Corner write at the last raster address, writer held valid
        wr_valid = 1'b1; wr_x = 9'd319; wr_y = 8'd239; wr_data = 8'hC8;
        #1 check("wr.ready0", 32'(wr_ready), 1);
        step();
        check("wr.en", 32'(mem_en), 1);
        check("wr.we", 32'(mem_we), 1);
        check("wr.addr", 32'(mem_addr), 76799);
        check("wr.data", 32'(mem_wdata), 32'hC8);
        check("wr.busy_ready", 32'(wr_ready), 0);
        step();
        check("wr.en_drop", 32'(mem_en), 0);
        check("wr.we_drop", 32'(mem_we), 0);
        check("wr.regrant_ready", 32'(wr_ready), 1);
        step();
        check("wr.second_we", 32'(mem_we), 1);
        wr_valid = 1'b0;
        step();
        check("wr.second_drop", 32'(mem_en), 0);
        show(319, 239, 8'hC8, "wr.readback");

        // Pixel change on the edge that registers a write
        wr_valid = 1'b1; wr_x = 9'd10; wr_y = 8'd200; wr_data = 8'h77;
        pixel = 9'd7; line = 8'd3;
        #1 check("col.ready", 32'(wr_ready), 1);
        step();
        check("col.wr_we", 32'(mem_we), 1);
        check("col.wr_addr", 32'(mem_addr), 64010);
        check("col.wr_data", 32'(mem_wdata), 32'h77);
        wr_valid = 1'b0;
        step();
        check("col.e1_en", 32'(mem_en), 0);
        check("col.e1_ready", 32'(wr_ready), 0);
        step();
        check("col.e2_en", 32'(mem_en), 1);
        check("col.e2_we", 32'(mem_we), 0);
        check("col.e2_addr", 32'(mem_addr), 967);
        step();
        check("col.e3_video", 32'(video), 32'(cur_video));
        step();
        check("col.e4_video", 32'(video), 32'(pat(967)));
        cur_video = pat(967);
        repeat (3) step();

        // Off-raster display slot; a waiting write takes the freed cycle
        pixel = 9'd330; line = 8'd5;
        step();
        check("offd.pend_ready", 32'(wr_ready), 0);
        wr_valid = 1'b1; wr_x = 9'd1; wr_y = 8'd150; wr_data = 8'h11;
        step();
        check("offd.no_rd", 32'(mem_en), 0);
        check("offd.video", 32'(video), 0);
        check("offd.ready", 32'(wr_ready), 1);
        step();
        check("offd.wr_en", 32'(mem_en), 1);
        check("offd.wr_we", 32'(mem_we), 1);
        check("offd.wr_addr", 32'(mem_addr), 48001);
        wr_valid = 1'b0;
        repeat (6) step();
        cur_video = 8'h00;

        // Off-raster writes are accepted and counted, no RAM cycle
        wr_valid = 1'b1; wr_x = 9'd320; wr_y = 8'd5; wr_data = 8'h99;
        #1 check("clip.ready", 32'(wr_ready), 1);
        step();
        check("clip.x_no_en", 32'(mem_en), 0);
        check("clip.x_cnt", 32'(clip_cnt), 1);
        check("clip.x_ready", 32'(wr_ready), 1);
        wr_x = 9'd0; wr_y = 8'd240;
        step();
        check("clip.y_no_en", 32'(mem_en), 0);
        check("clip.y_cnt", 32'(clip_cnt), 2);
        wr_valid = 1'b0;
        exp_clip = 2;
        step();

        // Randomized traffic against the transaction-level model
        prev_px = 330; prev_ln = 5; prev_hs_on = 1'b0;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    px = $urandom_range(320, 511); ln = $urandom_range(0, 255);
                end else begin
                    px = $urandom_range(0, 319); ln = $urandom_range(240, 255);
                end
            end else begin
                px = $urandom_range(0, 319); ln = $urandom_range(0, 99);
            end
            changed = (px != prev_px) || (ln != prev_ln);
            pixel = 9'(px); line = 8'(ln);
            exp_v = on_raster(px, ln) ? pat(addr_of(px, ln)) : 8'h00;
            for (int k = 0; k < 8; k++) begin
                wr_valid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    wr_x = 9'($urandom_range(320, 511)); wr_y = 8'($urandom_range(0, 255));
                end else begin
                    wr_x = 9'($urandom_range(0, 319)); wr_y = 8'($urandom_range(100, 239));
                end
                wr_data = 8'($urandom);
                #1;
                hs = wr_valid && wr_ready;
                hs_on = hs && on_raster(int'(wr_x), int'(wr_y));
                if (hs_on) begin
                    check("rnd.wr_spacing", 32'(prev_hs_on), 0);
                    a = addr_of(int'(wr_x), int'(wr_y));
                    wq.push_back(a * 256 + int'(wr_data));
                    exp_mem[a] = wr_data;
                    waddrs.push_back(a);
                end else if (hs && exp_clip < 65535) begin
                    exp_clip++;
                end
                prev_hs_on = hs_on;
                step();
                if (mem_en && mem_we) begin
                    if (wq.size() == 0) begin
                        check("rnd.wr_unexpected", 1, 0);
                    end else begin
                        e = wq.pop_front();
                        check("rnd.wr_addr", 32'(mem_addr), e / 256);
                        check("rnd.wr_data", 32'(mem_wdata), e % 256);
                    end
                end else if (mem_en) begin
                    check("rnd.rd_addr", 32'(mem_addr), addr_of(px, ln));
                end
                if (k == 0 && changed) check("rnd.pend_ready", 32'(wr_ready), 0);
                if (k == 4 || k == 7) check("rnd.video", 32'(video), 32'(exp_v));
            end
            prev_px = px; prev_ln = ln;
        end
        wr_valid = 1'b0;
        repeat (2) step();
        check("rnd.wr_drain", 32'(wq.size()), 0);
        check("rnd.clip_cnt", 32'(clip_cnt), 32'(exp_clip));
        foreach (waddrs[i]) begin
            check("rnd.ram", {23'd0, ram_wr[waddrs[i]], ram[waddrs[i]]}, {23'd0, 1'b1, exp_mem[waddrs[i]]});
        end

        // Clip counter saturation
        wr_valid = 1'b1; wr_x = 9'd400; wr_y = 8'd0;
        #1 check("sat.ready", 32'(wr_ready), 1);
        n = 65534 - exp_clip;
        repeat (n) step();
        check("sat.pre", 32'(clip_cnt), 32'hFFFE);
        step();
        check("sat.max", 32'(clip_cnt), 32'hFFFF);
        repeat (3) step();
        check("sat.hold", 32'(clip_cnt), 32'hFFFF);
        check("sat.no_en", 32'(mem_en), 0);
        wr_valid = 1'b0;

        // Reset with a read in flight
        pixel = 9'd511; line = 8'd255;
        repeat (8) step();
        pixel = 9'd9; line = 8'd9;
        step();
        step();
        check("mrst.rd_issued", 32'(mem_en), 1);
        reset = 1'b1;
        step();
        check("mrst.en", 32'(mem_en), 0);
        check("mrst.we", 32'(mem_we), 0);
        check("mrst.video", 32'(video), 0);
        check("mrst.ready", 32'(wr_ready), 0);
        check("mrst.clip", 32'(clip_cnt), 0);
        step();
        check("mrst.video_dropped", 32'(video), 0);
        reset = 1'b0;
        repeat (10) step();
        check("mrst.refetch", 32'(video), 32'(pat(2889)));
        check("mrst.idle_ready", 32'(wr_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
